// File: rtl/program_counter_unit_pkg.sv
// Shared MIPS core definitions: PC state encoding, slot/vector defaults and the PC type.
package mips_pkg;

   typedef enum logic {
      RUN = 1'b0,
      ISR = 1'b1
   } pc_state_e;

   localparam int DEF_WIDTH       = 32;
   localparam int DEF_PROG_SEL_W  = 2;
   localparam int DEF_SLOT_STRIDE = 15;
   localparam int DEF_STEP        = 1;
   localparam int DEF_IRQ_VECTOR  = 60;

   typedef logic [DEF_WIDTH-1:0] pc_t;

endpackage

// File: rtl/program_counter_unit_if.sv
// Control/fetch-side bundle of the program counter unit.
// master = next-PC mux / control unit side, slave = program counter unit.
interface program_counter_unit_if #(
   parameter int WIDTH      = 32,
   parameter int PROG_SEL_W = 2
);
   logic [PROG_SEL_W-1:0] progr;
   logic                  stall;
   logic                  branch_taken;
   logic [WIDTH-1:0]      branch_target;
   logic                  interrupt;
   logic                  eret;
   logic [WIDTH-1:0]      pc;
   logic [WIDTH-1:0]      epc;
   logic                  in_isr;
   logic                  irq_ack;

   modport master (
      output progr, stall, branch_taken, branch_target, interrupt, eret,
      input  pc, epc, in_isr, irq_ack
   );

   modport slave (
      input  progr, stall, branch_taken, branch_target, interrupt, eret,
      output pc, epc, in_isr, irq_ack
   );
endinterface

// File: rtl/program_counter_unit_reset_vector_rom.sv
// Maps a program slot to its reset vector. Combinational so it can later be
// replaced by a table of arbitrary slot addresses.
module reset_vector_rom
   import mips_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int PROG_SEL_W  = DEF_PROG_SEL_W,
   parameter int SLOT_STRIDE = DEF_SLOT_STRIDE
) (
   input  logic [PROG_SEL_W-1:0] progr_i,
   output logic [WIDTH-1:0]      vec_o
);

   // Product formed wide enough to never overflow, then truncated to WIDTH.
   localparam int PW = WIDTH + PROG_SEL_W + 32;

   // Slot base address = slot index times slot stride, mod 2^WIDTH.
   always_comb begin
      vec_o = WIDTH'(PW'(progr_i) * PW'(SLOT_STRIDE));
   end

endmodule

// File: rtl/program_counter_unit.sv
// Architectural PC and exception return address with reset vector table,
// stall, branch/jump redirect and single-level interrupt entry/return.
//
// state | meaning
// RUN   | normal sequential / redirected fetch, interrupts accepted
// ISR   | executing interrupt handler, new interrupts ignored, eret returns
module program_counter_unit
   import mips_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int PROG_SEL_W  = DEF_PROG_SEL_W,
   parameter int SLOT_STRIDE = DEF_SLOT_STRIDE,
   parameter int STEP        = DEF_STEP,
   parameter int IRQ_VECTOR  = DEF_IRQ_VECTOR
) (
   input  logic                   clock,
   input  logic                   reset,
   program_counter_unit_if.slave  bus
);

   logic [WIDTH-1:0] rst_vec;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic [WIDTH-1:0] pc_inc;
   pc_state_e        state_q, state_d;
   logic             pending_q, pending_d;
   logic             irq_ack_q, irq_ack_d;
   logic             in_isr_q, in_isr_d;
   logic             accept;

   reset_vector_rom #(
      .WIDTH       (WIDTH),
      .PROG_SEL_W  (PROG_SEL_W),
      .SLOT_STRIDE (SLOT_STRIDE)
   ) u_reset_vector_rom (
      .progr_i (bus.progr),
      .vec_o   (rst_vec)
   );

   // Next-state selection in priority order: accept, eret, stall, redirect, step.
   always_comb begin
      pc_d      = pc_q;
      epc_d     = epc_q;
      state_d   = state_q;
      pending_d = pending_q;
      irq_ack_d = 1'b0;
      pc_inc    = pc_q + WIDTH'(STEP);
      accept    = (state_q == RUN) && (pending_q || bus.interrupt) && !bus.stall;

      if (accept) begin
         // Return address is where fetch would have gone this cycle.
         epc_d     = bus.branch_taken ? bus.branch_target : pc_inc;
         pc_d      = WIDTH'(IRQ_VECTOR);
         state_d   = ISR;
         pending_d = 1'b0;
         irq_ack_d = 1'b1;
      end else if ((state_q == ISR) && bus.eret && !bus.stall) begin
         pc_d    = epc_q;
         state_d = RUN;
      end else if (bus.stall) begin
         // A request seen during a stall is held until the stall lifts.
         if ((state_q == RUN) && bus.interrupt) begin
            pending_d = 1'b1;
         end
      end else if (bus.branch_taken) begin
         pc_d = bus.branch_target;
      end else begin
         pc_d = pc_inc;
      end

      in_isr_d = (state_d == ISR);
   end

   // State register with synchronous reset; reset aborts any handler in progress.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q      <= rst_vec;
         epc_q     <= '0;
         state_q   <= RUN;
         pending_q <= 1'b0;
         irq_ack_q <= 1'b0;
         in_isr_q  <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         epc_q     <= epc_d;
         state_q   <= state_d;
         pending_q <= pending_d;
         irq_ack_q <= irq_ack_d;
         in_isr_q  <= in_isr_d;
      end
   end

   assign bus.pc      = pc_q;
   assign bus.epc     = epc_q;
   assign bus.in_isr  = in_isr_q;
   assign bus.irq_ack = irq_ack_q;

endmodule

// File: doc/program_counter_unit.md
Name: program_counter_unit

Overview:
- Parametrised next-generation program counter for the MIPS core.
- Adds a per-program reset vector table, pipeline stall, and branch/jump redirect.
- Adds single-level interrupt entry with a saved exception PC (EPC) and return-from-exception.
- Sits between the next-PC mux / control unit and instruction memory. Owns the architectural PC and the exception return address.

Parameters:
WIDTH, 32, PC / address width in bits
PROG_SEL_W, 2, width of program-slot select `progr`
SLOT_STRIDE, 15, instruction-memory distance between program slots; reset vector = progr*SLOT_STRIDE
STEP, 1, sequential increment (word-addressed instruction memory)
IRQ_VECTOR, 60, interrupt handler entry address

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
progr  in  PROG_SEL_W  program slot selected at reset
stall  in  1  hold PC (hazard / memory wait)
branch_taken  in  1  redirect to branch_target this cycle
branch_target  in  WIDTH  redirect address
interrupt  in  1  external interrupt request, level, sampled each cycle
eret  in  1  return from exception (one-cycle pulse from decode)
pc  out  WIDTH  current program counter (registered)
epc  out  WIDTH  saved return address (registered)
in_isr  out  1  high while executing handler
irq_ack  out  1  one-cycle pulse in the cycle after interrupt is accepted

Behaviour:
- Reset:
  - pc <= (progr*SLOT_STRIDE) mod 2^WIDTH. Every progr value is legal, including 2'b10 -> 30.
  - epc <= 0, in_isr <= 0, pending <= 0, irq_ack <= 0, state <= RUN.
  - Reset asserted mid-handler aborts the handler; no state survives.
- Interrupt latch:
  - pending <= 1 when interrupt is 1 and state==RUN.
  - pending clears when the interrupt is accepted.
  - interrupt while state==ISR is ignored: not queued, no nesting.
- FSM states: RUN, ISR. in_isr = (state==ISR), registered.
- Per-cycle priority when not in reset:
  1. Accept: state==RUN, (pending|interrupt), stall==0.
     - epc <= branch_taken ? branch_target : pc+STEP.
     - pc <= IRQ_VECTOR; state <= ISR; irq_ack <= 1 next cycle only.
  2. eret, state==ISR, stall==0: pc <= epc; state <= RUN. epc is unchanged.
  3. stall==1: pc, epc and state hold. A pending interrupt remains pending. branch_taken is ignored; decode must re-present it after the stall.
  4. branch_taken: pc <= branch_target.
  5. Otherwise: pc <= pc+STEP.
- Edge cases:
  - eret while state==RUN is a no-op (falls through to rows 3–5).
  - Accept and eret are mutually exclusive by state.
  - A redirect with interrupt in the same cycle saves branch_target in epc (row 1).
- Arithmetic:
  - All adds are unsigned, mod 2^WIDTH; pc = 2^WIDTH-1 increments to 0 with no flag.
  - Reset-vector product is computed at full width and then truncated to WIDTH.
- Latency: every pc change is visible one cycle after the qualifying inputs. There is no combinational input-to-pc path.

Decomposition:
- Shared package (mips_pkg):
  - PC state enum {RUN, ISR}.
  - Defaults for SLOT_STRIDE and IRQ_VECTOR, shared with the loader and instruction memory.
  - pc_t typedef sized by WIDTH.
- Sub-module reset_vector_rom: maps progr to its reset vector. It is combinational, so it can later become a table of arbitrary slot addresses.
- All remaining logic lives in a single always block in program_counter_unit.

Test Plan:
- Reset: progr=2'b10, reset one cycle, then release with stall=0 -> pc=30, then 31, then 32; epc=0, in_isr=0.
- Redirect with stall: branch_taken=1, branch_target=100 at pc=5 -> pc=100 next cycle. stall=1 for 3 cycles -> pc holds 100, branch_taken during the stall is ignored.
- Interrupt entry/return:
  - interrupt pulse at pc=7 -> next cycle pc=60, epc=8, in_isr=1, irq_ack=1 for exactly one cycle.
  - 4 handler cycles later, eret -> pc=8, in_isr=0.
- Pending across stall: interrupt pulse while stall=1 at pc=20, stall held 2 more cycles -> pc stays 20, then on stall release pc=60, epc=21.
- Simultaneous and nested events:
  - interrupt with branch_taken=1, target=200 -> pc=60, epc=200.
  - A second interrupt while in_isr=1 -> ignored; after eret, pc=200 and no re-entry.
- Wrap and mid-handler reset:
  - WIDTH=8, pc=255 -> pc=0.
  - reset while in_isr=1 with progr=2'b01 -> pc=15, in_isr=0, epc=0.
  - eret afterwards -> no-op, pc=16.
